calc_seq_ctrl: RTL and testbench

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

---
 rtl/calc_seq_ctrl_pkg.sv | 36 +++
 rtl/calc_seq_ctrl_btn_debounce.sv | 79 +++++++
 rtl/calc_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_calc_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_ctrl_pkg
// Purpose  : Shared encodings for the calculator sequencing controller:
//            one-hot state codes, display-select codes, state_led indices.
// Revision : 1.0  initial release
// ============================================================================
package calc_seq_ctrl_pkg;

    // state_led bit positions; states are one-hot so state_led is the state
    localparam int LED_ENTER_A  = 0;
    localparam int LED_ENTER_B  = 1;
    localparam int LED_SHOW_SUM = 2;
    localparam int LED_CYCLE    = 3;

    localparam logic [3:0] ST_ENTER_A  = 4'b0001 << LED_ENTER_A;
    localparam logic [3:0] ST_ENTER_B  = 4'b0001 << LED_ENTER_B;
    localparam logic [3:0] ST_SHOW_SUM = 4'b0001 << LED_SHOW_SUM;
    localparam logic [3:0] ST_CYCLE    = 4'b0001 << LED_CYCLE;

    // display select codes understood by the downstream datapath
    localparam logic [1:0] SEL_A   = 2'b10;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_SUM = 2'b00;

    // auto-cycle order A -> B -> SUM -> A; the unused code recovers to A
    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        case (sel)
            SEL_A:   next_sel = SEL_B;
            SEL_B:   next_sel = SEL_SUM;
            default: next_sel = SEL_A;
        endcase
    endfunction

endpackage : calc_seq_ctrl_pkg
`default_nettype wire

// File: rtl/calc_seq_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-flop synchronizer, stability-window debouncer and registered
//            rising-edge pulse for one raw push button.
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce
    import calc_seq_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int            CW         = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [1:0]    vld_q, vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic          armed_q, armed_d;

    // Debounce: level follows the synchronized input only after it has
    // disagreed for DB_CYCLES consecutive cycles. Pulses are withheld until a
    // released button has been seen after reset, so a button held through
    // reset cannot fire until it is let go and pressed again.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        armed_d = armed_q;
        vld_d   = {vld_q[0], 1'b1};
        if (sync2_q != level_q) begin
            if (cnt_q == C_CNT_LAST) begin
                cnt_d   = '0;
                level_d = sync2_q;
                pulse_d = sync2_q & armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
        if (vld_q[1] && !sync2_q && !level_q && (cnt_q == '0)) begin
            armed_d = 1'b1;
        end
    end

    // Synchronizer and debounce state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            armed_q <= armed_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_ctrl
// Purpose  : Operand entry / display sequencing controller for a 4-bit
//            sign-magnitude calculator; drives operands and display select.
// Revision : 1.0  initial release
// ============================================================================
module calc_seq_ctrl
    import calc_seq_ctrl_pkg::*;
#(
    parameter int DB_CYCLES    = 1_000_000,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clr,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [1:0] selector,
    output logic [3:0] state_led
);

    localparam int            DW           = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] C_DWELL_LAST = DW'(DWELL_CYCLES - 1);

    logic          enter_p, clr_p;
    logic [3:0]    state_q, state_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] dwell_q, dwell_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_enter),
        .pulse_o (enter_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_clr),
        .pulse_o (clr_p)
    );

    // Next-state logic; clear overrides everything, including a same-cycle enter
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        dwell_d = '0;
        case (state_q)
            ST_ENTER_A: begin
                a_d   = sw;
                sel_d = SEL_A;
                if (enter_p) begin
                    state_d = ST_ENTER_B;
                    sel_d   = SEL_B;
                end
            end
            ST_ENTER_B: begin
                b_d   = sw;
                sel_d = SEL_B;
                if (enter_p) begin
                    state_d = ST_SHOW_SUM;
                    sel_d   = SEL_SUM;
                end
            end
            ST_SHOW_SUM: begin
                sel_d = SEL_SUM;
                if (enter_p) begin
                    state_d = ST_CYCLE;
                    sel_d   = SEL_A;
                end
            end
            ST_CYCLE: begin
                if (enter_p) begin
                    state_d = ST_SHOW_SUM;
                    sel_d   = SEL_SUM;
                end else if (dwell_q == C_DWELL_LAST) begin
                    sel_d = next_sel(sel_q);
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ENTER_A;
                a_d     = sw;
                b_d     = 4'b0000;
                sel_d   = SEL_A;
            end
        endcase
        if (clr_p) begin
            state_d = ST_ENTER_A;
            a_d     = sw;
            b_d     = 4'b0000;
            sel_d   = SEL_A;
            dwell_d = '0;
        end
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ENTER_A;
            a_q     <= 4'b0000;
            b_q     <= 4'b0000;
            sel_q   <= SEL_A;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign selector  = sel_q;
    assign state_led = state_q;

endmodule : calc_seq_ctrl
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_seq_ctrl
// Purpose  : Directed self-checking bench for calc_seq_ctrl
//            (DB_CYCLES = 4, DWELL_CYCLES = 8).
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_seq_ctrl;

    localparam int DB = 4;
    localparam int DW = 8;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [3:0] sw        = 4'b0000;
    logic       btn_enter = 1'b0;
    logic       btn_clr   = 1'b0;
    logic [3:0] a, b;
    logic [1:0] selector;
    logic [3:0] state_led;

    int n_checks = 0;
    int n_fail   = 0;

    calc_seq_ctrl #(.DB_CYCLES(DB), .DWELL_CYCLES(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clr   (btn_clr),
        .a         (a),
        .b         (b),
        .selector  (selector),
        .state_led (state_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        tick(8);
        btn_enter = 1'b0;
        tick(8);
    endtask

    task automatic press_clr();
        btn_clr = 1'b1;
        tick(8);
        btn_clr = 1'b0;
        tick(8);
    endtask

    logic [3:0] prev;
    int         tr;
    bit         found;

    initial begin
        // ---------------- reset values
        tick(3);
        check("rst_a",   32'(a),         32'h0);
        check("rst_b",   32'(b),         32'h0);
        check("rst_sel", 32'(selector),  32'h2);
        check("rst_led", 32'(state_led), 32'h1);
        reset = 1'b1;
        tick(8);
        check("idle_led", 32'(state_led), 32'h1);

        // ---------------- enter A held 10 cycles, exactly one advance
        sw   = 4'b0101;
        prev = state_led;
        tr   = 0;
        btn_enter = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) btn_enter = 1'b0;
            tick(1);
            if (state_led !== prev) tr++;
            prev = state_led;
        end
        check("hold_a",     32'(a),         32'h5);
        check("hold_led",   32'(state_led), 32'h2);
        check("hold_sel",   32'(selector),  32'h1);
        check("hold_trans", 32'(tr),        32'd1);

        // ---------------- glitches shorter than debounce window
        sw = 4'b1010;
        for (int g = 0; g < 3; g++) begin
            btn_enter = 1'b1;
            tick(3);
            btn_enter = 1'b0;
            tick(4);
        end
        tick(6);
        check("glitch_led", 32'(state_led), 32'h2);
        check("glitch_b",   32'(b),         32'hA);
        press_enter();
        check("b_led", 32'(state_led), 32'h4);
        check("b_sel", 32'(selector),  32'h0);
        check("b_a",   32'(a),         32'h5);
        check("b_b",   32'(b),         32'hA);

        // ---------------- clear from SHOW_SUM
        sw = 4'b0110;
        press_clr();
        check("clr_led", 32'(state_led), 32'h1);
        check("clr_b",   32'(b),         32'h0);
        check("clr_a",   32'(a),         32'h6);
        check("clr_sel", 32'(selector),  32'h2);

        // ---------------- A=0011, B=1010, then auto-cycle
        sw = 4'b0011;
        press_enter();
        check("ea_led", 32'(state_led), 32'h2);
        check("ea_a",   32'(a),         32'h3);
        sw = 4'b1010;
        press_enter();
        check("eb_led", 32'(state_led), 32'h4);
        check("eb_sel", 32'(selector),  32'h0);
        check("eb_a",   32'(a),         32'h3);
        check("eb_b",   32'(b),         32'hA);

        btn_enter = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (state_led === 4'b1000) found = 1'b1;
        end
        check("cyc_enter", 32'(found),    32'd1);
        check("cyc_sel0",  32'(selector), 32'h2);
        btn_enter = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            tick(1);
            case (k)
                7:  check("cyc_sel_k7",  32'(selector), 32'h2);
                8:  check("cyc_sel_k8",  32'(selector), 32'h1);
                15: check("cyc_sel_k15", 32'(selector), 32'h1);
                16: check("cyc_sel_k16", 32'(selector), 32'h0);
                23: check("cyc_sel_k23", 32'(selector), 32'h0);
                24: check("cyc_sel_k24", 32'(selector), 32'h2);
                default: ;
            endcase
        end
        check("cyc_led", 32'(state_led), 32'h8);
        check("cyc_a",   32'(a),         32'h3);
        check("cyc_b",   32'(b),         32'hA);

        // ---------------- clr and enter same cycle in CYCLE: clr wins
        sw = 4'b1111;
        btn_enter = 1'b1;
        btn_clr   = 1'b1;
        tick(8);
        btn_enter = 1'b0;
        btn_clr   = 1'b0;
        tick(8);
        check("both_led",   32'(state_led),   32'h1);
        check("both_b",     32'(b),           32'h0);
        check("both_sel",   32'(selector),    32'h2);
        check("both_dwell", 32'(dut.dwell_q), 32'h0);

        // ---------------- reset mid-CYCLE with enter held through release
        sw = 4'b0001;
        press_enter();
        sw = 4'b0010;
        press_enter();
        press_enter();
        check("re_cyc_led", 32'(state_led), 32'h8);
        tick(3);
        btn_enter = 1'b1;
        tick(2);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_a",   32'(a),         32'h0);
        check("mid_rst_b",   32'(b),         32'h0);
        check("mid_rst_sel", 32'(selector),  32'h2);
        check("mid_rst_led", 32'(state_led), 32'h1);
        check("mid_rst_dw",  32'(dut.dwell_q), 32'h0);
        tick(2);
        reset = 1'b1;
        prev = state_led;
        tr   = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (state_led !== prev) tr++;
            prev = state_led;
        end
        check("held_trans", 32'(tr),        32'd0);
        check("held_led",   32'(state_led), 32'h1);
        check("held_a",     32'(a),         32'h2);
        check("held_b",     32'(b),         32'h0);
        btn_enter = 1'b0;
        tick(10);
        check("rel_led", 32'(state_led), 32'h1);
        press_enter();
        check("repress_led", 32'(state_led), 32'h2);
        check("repress_a",   32'(a),         32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_calc_seq_ctrl
`default_nettype wire
